humidity_multi_conv: RTL and testbench

Parametrised, multi-channel successor to the greenhouse humidity lookup converter. It accepts tagged 12-bit ADC samples from several humidity sensors over a valid/ready stream. Each sample is converted arithmetically to humidity in tenths of a percent, saturated, and smoothed by a per-channel moving average. It sits between the ADC sequencer and the control/telemetry logic.

---
 rtl/humidity_multi_conv.sv | 195 +++++++++++++++++++
 tb/tb_humidity_multi_conv.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/humidity_multi_conv.sv
// Multi-channel ADC-to-humidity converter: offset/scale, saturation at HUM_MAX,
// optional per-channel moving average (enabled by defining HUM_AVG_EN).
module humidity_multi_conv #(
  parameter int CHANNELS = 4,
  parameter int ADC_W    = 12,
  parameter int HUM_W    = 10,
  parameter int V_OFFSET = 2009,
  parameter int HUM_MAX  = 1000,
  parameter int AVG_LOG2 = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_chan,
  input  logic [ADC_W-1:0] in_voltage,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_chan,
  output logic [HUM_W-1:0] out_humidity,
  output logic             out_sat,
  output logic             chan_err
);

  localparam logic [ADC_W-1:0] OFFSET_C = ADC_W'(V_OFFSET);
  localparam logic [ADC_W-1:0] MAX_C    = ADC_W'(HUM_MAX);

  logic             w_en;
  logic             w_xfer;
  logic             w_tag_ok;
  logic [ADC_W-1:0] w_diff;
  logic [ADC_W-1:0] w_half;
  logic [HUM_W-1:0] w_raw;
  logic             w_sat;

  logic             w_out_valid;
  logic [CH_W-1:0]  w_out_chan;
  logic [HUM_W-1:0] w_out_hum;
  logic             w_out_sat;

  logic             r_s1_valid;
  logic [CH_W-1:0]  r_s1_chan;
  logic [HUM_W-1:0] r_s1_raw;
  logic             r_s1_sat;
  logic             r_chan_err;

  // A held output freezes the whole pipeline.
  assign w_en     = !(w_out_valid && !out_ready);
  assign w_xfer   = in_valid && w_en;
  assign w_tag_ok = ({1'b0, in_chan} < (CH_W + 1)'(CHANNELS));

  // Offset removal, halving and clipping of the raw ADC code.
  always_comb begin
    w_diff = '0;
    w_half = '0;
    w_raw  = '0;
    w_sat  = 1'b0;
    if (in_voltage > OFFSET_C) begin
      w_diff = in_voltage - OFFSET_C;
    end else begin
      w_diff = '0;
    end
    w_half = w_diff >> 1;
    if (w_half > MAX_C) begin
      w_raw = HUM_W'(HUM_MAX);
      w_sat = 1'b1;
    end else begin
      w_raw = HUM_W'(w_half);
      w_sat = 1'b0;
    end
  end

  // Stage 1 register; samples with a bad tag only raise the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_chan  <= '0;
      r_s1_raw   <= '0;
      r_s1_sat   <= 1'b0;
      r_chan_err <= 1'b0;
    end else begin
      r_chan_err <= w_xfer && !w_tag_ok;
      if (w_en) begin
        r_s1_valid <= w_xfer && w_tag_ok;
        if (w_xfer && w_tag_ok) begin
          r_s1_chan <= in_chan;
          r_s1_raw  <= w_raw;
          r_s1_sat  <= w_sat;
        end
      end
    end
  end

`ifdef HUM_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = HUM_W + AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [HUM_W-1:0]    r_hist [CHANNELS][DEPTH];
  logic [SUM_W-1:0]    r_sum  [CHANNELS];
  logic [PTR_W-1:0]    r_ptr  [CHANNELS];
  logic [CHANNELS-1:0] r_seeded;

  logic [HUM_W-1:0] w_old;
  logic [SUM_W-1:0] w_sum_nxt;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [HUM_W-1:0] w_avg;

  logic             r_out_valid;
  logic [CH_W-1:0]  r_out_chan;
  logic [HUM_W-1:0] r_out_hum;
  logic             r_out_sat;

  // Running-sum update for the channel currently in stage 1; an unseeded
  // channel starts as if its whole window held this sample.
  always_comb begin
    w_old     = r_hist[r_s1_chan][r_ptr[r_s1_chan]];
    w_sum_nxt = '0;
    w_ptr_nxt = '0;
    if (AVG_LOG2 == 0) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_ptr[r_s1_chan] + PTR_W'(1);
    end
    if (!r_seeded[r_s1_chan]) begin
      w_sum_nxt = SUM_W'(r_s1_raw) << AVG_LOG2;
    end else begin
      w_sum_nxt = r_sum[r_s1_chan] - SUM_W'(w_old) + SUM_W'(r_s1_raw);
    end
    w_avg = HUM_W'(w_sum_nxt >> AVG_LOG2);
  end

  // Per-channel history, pointer, sum and seeded state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seeded <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_sum[c] <= '0;
        r_ptr[c] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          r_hist[c][d] <= '0;
        end
      end
    end else if (w_en && r_s1_valid) begin
      r_sum[r_s1_chan] <= w_sum_nxt;
      if (!r_seeded[r_s1_chan]) begin
        r_seeded[r_s1_chan] <= 1'b1;
        r_ptr[r_s1_chan]    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          r_hist[r_s1_chan][d] <= r_s1_raw;
        end
      end else begin
        r_hist[r_s1_chan][r_ptr[r_s1_chan]] <= r_s1_raw;
        r_ptr[r_s1_chan]                    <= w_ptr_nxt;
      end
    end
  end

  // Output register; data only moves when a new result arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_hum   <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_chan <= r_s1_chan;
        r_out_hum  <= w_avg;
        r_out_sat  <= r_s1_sat;
      end
    end
  end

  assign w_out_valid = r_out_valid;
  assign w_out_chan  = r_out_chan;
  assign w_out_hum   = r_out_hum;
  assign w_out_sat   = r_out_sat;
`else
  assign w_out_valid = r_s1_valid;
  assign w_out_chan  = r_s1_chan;
  assign w_out_hum   = r_s1_raw;
  assign w_out_sat   = r_s1_sat;
`endif

  assign in_ready     = w_en;
  assign out_valid    = w_out_valid;
  assign out_chan     = w_out_chan;
  assign out_humidity = w_out_hum;
  assign out_sat      = w_out_sat;
  assign chan_err     = r_chan_err;

endmodule

// File: tb/tb_humidity_multi_conv.sv
// Self-checking bench for humidity_multi_conv: vector table, scoreboard queue,
// hand sequences for latency, bad tags, backpressure and mid-stream reset.
module tb_humidity_multi_conv;

  localparam int NCH = 5;  // five channels so tags 5..7 are representable and invalid
`ifdef HUM_AVG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_chan = 3'd0;
  logic [11:0] in_voltage = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_chan;
  logic [9:0]  out_humidity;
  logic        out_sat;
  logic        chan_err;

  humidity_multi_conv #(.CHANNELS(NCH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_voltage(in_voltage),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_humidity(out_humidity), .out_sat(out_sat), .chan_err(chan_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  chan;
    logic [11:0] v;
    logic [9:0]  e_avg;
    logic [9:0]  e_raw;
    logic        e_sat;
  } vec_t;

  typedef struct {
    logic [2:0] chan;
    logic [9:0] hum;
    logic       sat;
  } exp_t;

  vec_t       tbl [18];
  logic [9:0] bp_avg [8];
  exp_t       sb_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         lat;
  bit         found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] pick(input logic [9:0] avg_val, input logic [9:0] raw_val);
`ifdef HUM_AVG_EN
    return avg_val;
`else
    return raw_val;
`endif
  endfunction

  // Drives one sample and waits for it to be accepted; records the expectation.
  task automatic send(input logic [2:0] ch, input logic [11:0] v,
                      input logic [9:0] eh, input logic es);
    logic rdy;
    bit   done;
    done       = 1'b0;
    in_valid   = 1'b1;
    in_chan    = ch;
    in_voltage = v;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
    end
    if (done) begin
      if (ch < NCH) sb_q.push_back('{ch, eh, es});
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no transfer expected transfer for ch=%0d", ch);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 32'd0);
  endtask

  logic       prev_stall = 1'b0;
  logic [2:0] p_chan;
  logic [9:0] p_hum;
  logic       p_sat;

  // Output monitor: handshake rule, hold-while-stalled, scoreboard compare.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 32'd1);
        check("hold_chan", out_chan, p_chan);
        check("hold_hum", out_humidity, p_hum);
        check("hold_sat", out_sat, p_sat);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got chan=%0d hum=%0d expected none", out_chan, out_humidity);
        end else begin
          check("out_chan", out_chan, sb_q[0].chan);
          check("out_humidity", out_humidity, sb_q[0].hum);
          check("out_sat", out_sat, sb_q[0].sat);
          void'(sb_q.pop_front());
        end
      end
      prev_stall <= out_valid && !out_ready;
      p_chan     <= out_chan;
      p_hum      <= out_humidity;
      p_sat      <= out_sat;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    tbl[0]  = '{3'd0, 12'd2209, 10'd100,  10'd100,  1'b0};
    tbl[1]  = '{3'd2, 12'd3009, 10'd500,  10'd500,  1'b0};
    tbl[2]  = '{3'd0, 12'd2209, 10'd100,  10'd100,  1'b0};
    tbl[3]  = '{3'd2, 12'd3009, 10'd500,  10'd500,  1'b0};
    tbl[4]  = '{3'd0, 12'd2209, 10'd100,  10'd100,  1'b0};
    tbl[5]  = '{3'd2, 12'd3009, 10'd500,  10'd500,  1'b0};
    tbl[6]  = '{3'd1, 12'd2209, 10'd100,  10'd100,  1'b0};
    tbl[7]  = '{3'd1, 12'd2609, 10'd150,  10'd300,  1'b0};
    tbl[8]  = '{3'd1, 12'd2609, 10'd200,  10'd300,  1'b0};
    tbl[9]  = '{3'd1, 12'd2609, 10'd250,  10'd300,  1'b0};
    tbl[10] = '{3'd1, 12'd2609, 10'd300,  10'd300,  1'b0};
    tbl[11] = '{3'd3, 12'd2000, 10'd0,    10'd0,    1'b0};
    tbl[12] = '{3'd3, 12'd4009, 10'd250,  10'd1000, 1'b0};
    tbl[13] = '{3'd3, 12'd4095, 10'd500,  10'd1000, 1'b1};
    tbl[14] = '{3'd4, 12'd4095, 10'd1000, 10'd1000, 1'b1};
    tbl[15] = '{3'd4, 12'd2009, 10'd750,  10'd0,    1'b0};
    tbl[16] = '{3'd4, 12'd0,    10'd500,  10'd0,    1'b0};
    tbl[17] = '{3'd4, 12'd2011, 10'd250,  10'd1,    1'b0};
    bp_avg  = '{10'd100, 10'd110, 10'd130, 10'd160, 10'd200, 10'd240, 10'd280, 10'd320};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_chan", out_chan, 32'd0);
    check("rst_out_humidity", out_humidity, 32'd0);
    check("rst_out_sat", out_sat, 32'd0);
    check("rst_chan_err", chan_err, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single conversion and its latency.
    send(3'd0, 12'd2209, 10'd100, 1'b0);
    lat   = 0;
    found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat   = i;
        found = 1'b1;
      end
    end
    check("latency", lat, LAT);
    drain();

    // Vector table: interleave, ramp, limits.
    for (int i = 0; i < 18; i++) begin
      send(tbl[i].chan, tbl[i].v, pick(tbl[i].e_avg, tbl[i].e_raw), tbl[i].e_sat);
    end
    drain();

    // Invalid tags: error pulse only, then a normal sample.
    send(3'd5, 12'd2209, 10'd0, 1'b0);
    @(negedge clk);
    check("chan_err_pulse", chan_err, 32'd1);
    @(negedge clk);
    check("chan_err_clear", chan_err, 32'd0);
    @(posedge clk);
    #1;
    send(3'd7, 12'd4095, 10'd0, 1'b0);
    @(negedge clk);
    check("chan_err_pulse7", chan_err, 32'd1);
    @(posedge clk);
    #1;
    send(3'd0, 12'd2209, 10'd100, 1'b0);
    drain();

    // Backpressure: 8 ch0 samples with out_ready held low.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(3'd0, 12'(2209 + 80 * k), pick(bp_avg[k], 10'(100 + 40 * k)), 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_out_valid", out_valid, 32'd1);
        check("bp_in_ready_low", in_ready, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream discards in-flight samples and forces re-seeding.
    send(3'd2, 12'd3009, 10'd500, 1'b0);
    send(3'd2, 12'd3009, 10'd500, 1'b0);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 32'd0);
    check("mid_rst_out_chan", out_chan, 32'd0);
    check("mid_rst_out_humidity", out_humidity, 32'd0);
    check("mid_rst_in_ready", in_ready, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(3'd2, 12'd2409, 10'd200, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
